// File: rtl/l2_request_arbiter_nch.sv
// l2_request_arbiter_nch: N-channel block-transfer arbiter in front of the L2 cache.
// Several L1 requestors are multiplexed onto one L2 request port. The arbitration
// mode is round-robin or fixed priority, and each channel has a saturating grant counter.
//
// Ports:
//   clock_i, reset_i            single rising-edge clock, synchronous active-high reset
//   ch_req_i/ch_rw_i/ch_add_i   per-channel request, direction (1=write), word address
//   ch_wdata_i / ch_wnext_o     per-channel write word / word accepted (combinational)
//   ch_rdata_o / ch_rvalid_o    shared registered read word / per-channel valid
//   ch_done_o                   one-cycle transfer-complete pulse
//   l2_req_o/l2_rw_o/l2_add_o   registered L2 request, direction, block-aligned address
//   l2_ready_i                  L2 accepts the request
//   l2_data_i/l2_valid_i        L2 read word stream
//   l2_wdata_o/l2_wvalid_o      write word (combinational mux) / write valid
//   l2_wready_i                 L2 accepts the write word
//   grant_cnt_o                 per-channel saturating 32-bit grant counters
//   busy_o                      arbiter is not idle

`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 24
`endif

module l2_request_arbiter_nch #(
  parameter int unsigned N_CH          = 3,
  parameter int unsigned ADDR_W        = `BW_WORD_ADDR,
  parameter int unsigned BLOCK_WORDS   = 16,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [N_CH-1:0]          ch_req_i,
  input  logic [N_CH-1:0]          ch_rw_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_add_i,
  input  logic [N_CH*32-1:0]       ch_wdata_i,
  output logic [N_CH-1:0]          ch_wnext_o,
  output logic [31:0]              ch_rdata_o,
  output logic [N_CH-1:0]          ch_rvalid_o,
  output logic [N_CH-1:0]          ch_done_o,
  output logic                     l2_req_o,
  output logic                     l2_rw_o,
  output logic [ADDR_W-1:0]        l2_add_o,
  input  logic                     l2_ready_i,
  input  logic [31:0]              l2_data_i,
  input  logic                     l2_valid_i,
  output logic [31:0]              l2_wdata_o,
  output logic                     l2_wvalid_o,
  input  logic                     l2_wready_i,
  output logic [N_CH*32-1:0]       grant_cnt_o,
  output logic                     busy_o
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_W = OFF_W + 1;

  localparam logic [SUM_W-1:0]  N_CH_S    = SUM_W'(N_CH);
  localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   add_q, add_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [N_CH-1:0]     rvalid_q, rvalid_d;
  logic [N_CH-1:0]     done_q, done_d;
  logic                req_q, req_d;
  logic                wvalid_q, wvalid_d;
  logic                busy_q, busy_d;
  logic [N_CH*32-1:0]  grant_cnt_q, grant_cnt_d;

  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic [SUM_W-1:0]    cand;
  logic [ADDR_W-1:0]   sel_add;
  logic [31:0]         sel_cnt;
  logic [31:0]         wdata_sel;
  logic [N_CH-1:0]     grant_onehot;

  // Pick the winning requester: rotate from rr_ptr, or lowest index in fixed mode.
  always_comb begin : arbitration
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      if (PRIORITY_MODE == 1) begin
        cand = SUM_W'(off);
      end else begin
        cand = {1'b0, rr_ptr_q} + SUM_W'(off);
        if (cand >= N_CH_S) begin
          cand = cand - N_CH_S;
        end
      end
      if (!arb_found && ch_req_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_add      = ch_add_i[32'(arb_idx) * ADDR_W +: ADDR_W];
  assign sel_cnt      = grant_cnt_q[32'(arb_idx) * 32 +: 32];
  assign wdata_sel    = ch_wdata_i[32'(grant_q) * 32 +: 32];
  assign grant_onehot = N_CH'(1) << grant_q;

  // Next-state and next-output logic.
  always_comb begin : next_logic
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    rw_d        = rw_q;
    add_d       = add_q;
    rdata_d     = rdata_q;
    rvalid_d    = '0;
    grant_cnt_d = grant_cnt_q;

    case (state_q)
      ST_IDLE: begin
        word_cnt_d = '0;
        if (arb_found) begin
          grant_d = arb_idx;
          rw_d    = ch_rw_i[arb_idx];
          add_d   = sel_add & ADDR_MASK;
          if (sel_cnt != 32'hFFFF_FFFF) begin
            grant_cnt_d[32'(arb_idx) * 32 +: 32] = sel_cnt + 32'd1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (l2_ready_i) begin
          state_d = rw_q ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (l2_valid_i) begin
          rdata_d    = l2_data_i;
          rvalid_d   = grant_onehot;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (l2_wready_i) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    done_d   = (state_d == ST_DONE) ? grant_onehot : '0;
    req_d    = (state_d == ST_ISSUE);
    wvalid_d = (state_d == ST_WRITE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge clock_i) begin : regs
    if (reset_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      rw_q        <= 1'b0;
      add_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      done_q      <= '0;
      req_q       <= 1'b0;
      wvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      rw_q        <= rw_d;
      add_q       <= add_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      req_q       <= req_d;
      wvalid_q    <= wvalid_d;
      busy_q      <= busy_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign ch_rdata_o  = rdata_q;
  assign ch_rvalid_o = rvalid_q;
  assign ch_done_o   = done_q;
  assign l2_req_o    = req_q;
  assign l2_rw_o     = rw_q;
  assign l2_add_o    = add_q;
  assign l2_wvalid_o = wvalid_q;
  assign busy_o      = busy_q;
  assign grant_cnt_o = grant_cnt_q;

  // Write data path is a same-cycle pass-through, quiet outside WRITE.
  assign l2_wdata_o  = (state_q == ST_WRITE) ? wdata_sel : '0;
  assign ch_wnext_o  = ((state_q == ST_WRITE) && l2_wready_i) ? grant_onehot : '0;

endmodule

// File: tb/tb_l2_request_arbiter_nch.sv
// Directed bench for l2_request_arbiter_nch: a round-robin instance (dut) and a
// fixed-priority instance (p_dut) share all inputs.
module tb_l2_request_arbiter_nch;

  logic        clk;
  logic        rst;
  logic [2:0]  ch_req;
  logic [2:0]  ch_rw;
  logic [71:0] ch_add;
  logic [95:0] ch_wdata;
  logic        l2_ready;
  logic [31:0] l2_data;
  logic        l2_valid;
  logic        l2_wready;

  logic [2:0]  ch_wnext_o, ch_rvalid_o, ch_done_o;
  logic [31:0] ch_rdata_o, l2_wdata_o;
  logic        l2_req_o, l2_rw_o, l2_wvalid_o, busy_o;
  logic [23:0] l2_add_o;
  logic [95:0] grant_cnt_o;

  logic [2:0]  p_ch_wnext_o, p_ch_rvalid_o, p_ch_done_o;
  logic [31:0] p_ch_rdata_o, p_l2_wdata_o;
  logic        p_l2_req_o, p_l2_rw_o, p_l2_wvalid_o, p_busy_o;
  logic [23:0] p_l2_add_o;
  logic [95:0] p_grant_cnt_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  l2_request_arbiter_nch #(.N_CH(3), .ADDR_W(24), .BLOCK_WORDS(16), .PRIORITY_MODE(0)) dut (
    .clock_i(clk), .reset_i(rst), .ch_req_i(ch_req), .ch_rw_i(ch_rw), .ch_add_i(ch_add),
    .ch_wdata_i(ch_wdata), .ch_wnext_o(ch_wnext_o), .ch_rdata_o(ch_rdata_o),
    .ch_rvalid_o(ch_rvalid_o), .ch_done_o(ch_done_o), .l2_req_o(l2_req_o), .l2_rw_o(l2_rw_o),
    .l2_add_o(l2_add_o), .l2_ready_i(l2_ready), .l2_data_i(l2_data), .l2_valid_i(l2_valid),
    .l2_wdata_o(l2_wdata_o), .l2_wvalid_o(l2_wvalid_o), .l2_wready_i(l2_wready),
    .grant_cnt_o(grant_cnt_o), .busy_o(busy_o)
  );

  l2_request_arbiter_nch #(.N_CH(3), .ADDR_W(24), .BLOCK_WORDS(16), .PRIORITY_MODE(1)) p_dut (
    .clock_i(clk), .reset_i(rst), .ch_req_i(ch_req), .ch_rw_i(ch_rw), .ch_add_i(ch_add),
    .ch_wdata_i(ch_wdata), .ch_wnext_o(p_ch_wnext_o), .ch_rdata_o(p_ch_rdata_o),
    .ch_rvalid_o(p_ch_rvalid_o), .ch_done_o(p_ch_done_o), .l2_req_o(p_l2_req_o),
    .l2_rw_o(p_l2_rw_o), .l2_add_o(p_l2_add_o), .l2_ready_i(l2_ready), .l2_data_i(l2_data),
    .l2_valid_i(l2_valid), .l2_wdata_o(p_l2_wdata_o), .l2_wvalid_o(p_l2_wvalid_o),
    .l2_wready_i(l2_wready), .grant_cnt_o(p_grant_cnt_o), .busy_o(p_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input int ch, input logic [23:0] val);
    ch_add[ch*24 +: 24] = val;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    vec_cnt++; if (l2_req_o !== 1'b0) begin err_cnt++; $display("FAIL reset_l2_req got %0b want 0", l2_req_o); end
    vec_cnt++; if (l2_add_o !== 24'h0) begin err_cnt++; $display("FAIL reset_l2_add got %h want 0", l2_add_o); end
    vec_cnt++; if (grant_cnt_o !== 96'h0) begin err_cnt++; $display("FAIL reset_grant_cnt got %h want 0", grant_cnt_o); end
    vec_cnt++; if ({ch_done_o, ch_rvalid_o, ch_wnext_o} !== 9'h0) begin err_cnt++; $display("FAIL reset_ch_flags got %b want 0", {ch_done_o, ch_rvalid_o, ch_wnext_o}); end
    vec_cnt++; if ({l2_wvalid_o, l2_rw_o, l2_wdata_o, ch_rdata_o} !== 66'h0) begin err_cnt++; $display("FAIL reset_data got %h want 0", {l2_wvalid_o, l2_rw_o, l2_wdata_o, ch_rdata_o}); end
    vec_cnt++; if (p_busy_o !== 1'b0) begin err_cnt++; $display("FAIL reset_p_busy got %0b want 0", p_busy_o); end
  endtask

  task automatic test_read_ch1();
    logic [31:0] d;
    set_add(1, 24'h000123);
    ch_rw = 3'b000; ch_req = 3'b010; l2_ready = 1'b0; l2_valid = 1'b0;
    tick();  // IDLE -> ISSUE
    vec_cnt++; if (l2_req_o !== 1'b1) begin err_cnt++; $display("FAIL rd_issue_req got %0b want 1", l2_req_o); end
    vec_cnt++; if (l2_add_o !== 24'h000120) begin err_cnt++; $display("FAIL rd_issue_add got %h want 000120", l2_add_o); end
    vec_cnt++; if (l2_rw_o !== 1'b0) begin err_cnt++; $display("FAIL rd_issue_rw got %0b want 0", l2_rw_o); end
    vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL rd_busy got %0b want 1", busy_o); end
    vec_cnt++; if (grant_cnt_o[63:32] !== 32'd1) begin err_cnt++; $display("FAIL rd_grant_cnt1 got %0d want 1", grant_cnt_o[63:32]); end
    // Granted channel's address changes must not leak; valid during ISSUE is ignored.
    set_add(1, 24'hFFFFFF);
    l2_ready = 1'b1; l2_valid = 1'b1; l2_data = 32'hDEAD_BEEF;
    tick();  // ISSUE -> READ
    l2_ready = 1'b0;
    vec_cnt++; if (l2_req_o !== 1'b0) begin err_cnt++; $display("FAIL rd_req_drop got %0b want 0", l2_req_o); end
    vec_cnt++; if (ch_rvalid_o !== 3'b000) begin err_cnt++; $display("FAIL rd_issue_valid_ignored got %b want 000", ch_rvalid_o); end
    vec_cnt++; if (l2_add_o !== 24'h000120) begin err_cnt++; $display("FAIL rd_add_latched got %h want 000120", l2_add_o); end
    for (int i = 0; i < 16; i++) begin
      d = 32'hA500_0000 + 32'(i);
      l2_valid = 1'b1; l2_data = d;
      tick();
      vec_cnt++; if (ch_rvalid_o !== 3'b010) begin err_cnt++; $display("FAIL rd_rvalid[%0d] got %b want 010", i, ch_rvalid_o); end
      vec_cnt++; if (ch_rdata_o !== d) begin err_cnt++; $display("FAIL rd_rdata[%0d] got %h want %h", i, ch_rdata_o, d); end
      vec_cnt++; if (ch_done_o !== ((i == 15) ? 3'b010 : 3'b000)) begin err_cnt++; $display("FAIL rd_done[%0d] got %b want %b", i, ch_done_o, (i == 15) ? 3'b010 : 3'b000); end
    end
    l2_valid = 1'b0; ch_req = 3'b000;
    tick();
    vec_cnt++; if ({busy_o, ch_done_o, ch_rvalid_o} !== 7'h0) begin err_cnt++; $display("FAIL rd_after_done got %b want 0", {busy_o, ch_done_o, ch_rvalid_o}); end
  endtask

  task automatic test_reset_mid_read();
    // rr_ptr is 2 here, so a lone ch0 request still wins by wrapping.
    set_add(0, 24'h000200);
    ch_rw = 3'b000; ch_req = 3'b001;
    tick();
    vec_cnt++; if (l2_add_o !== 24'h000200) begin err_cnt++; $display("FAIL mid_wrap_grant_add got %h want 000200", l2_add_o); end
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l2_valid = 1'b1; l2_data = 32'h5000_0000 + 32'(i);
      tick();
      vec_cnt++; if (ch_rvalid_o !== 3'b001) begin err_cnt++; $display("FAIL mid_rvalid[%0d] got %b want 001", i, ch_rvalid_o); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; l2_valid = 1'b0;
    vec_cnt++; if ({busy_o, l2_req_o, l2_rw_o, l2_wvalid_o} !== 4'h0) begin err_cnt++; $display("FAIL mid_rst_flags got %b want 0000", {busy_o, l2_req_o, l2_rw_o, l2_wvalid_o}); end
    vec_cnt++; if ({ch_rvalid_o, ch_done_o, ch_wnext_o} !== 9'h0) begin err_cnt++; $display("FAIL mid_rst_ch got %b want 0", {ch_rvalid_o, ch_done_o, ch_wnext_o}); end
    vec_cnt++; if ({l2_add_o, ch_rdata_o, l2_wdata_o} !== 88'h0) begin err_cnt++; $display("FAIL mid_rst_data got %h want 0", {l2_add_o, ch_rdata_o, l2_wdata_o}); end
    vec_cnt++; if (grant_cnt_o !== 96'h0) begin err_cnt++; $display("FAIL mid_rst_cnt got %h want 0", grant_cnt_o); end
    set_add(1, 24'h000300); set_add(2, 24'h000400);
    ch_req = 3'b111;
    tick();
    vec_cnt++; if (l2_add_o !== 24'h000200) begin err_cnt++; $display("FAIL mid_regrant_add got %h want 000200", l2_add_o); end
    vec_cnt++; if (grant_cnt_o !== {32'd0, 32'd0, 32'd1}) begin err_cnt++; $display("FAIL mid_regrant_cnt got %h want 1 on ch0", grant_cnt_o); end
    ch_req = 3'b000;
    pulse_reset();
  endtask

  task automatic test_round_robin();
    int cyc, last_done, n_issue, n_done;
    logic prev_req;
    logic [23:0] exp_add;
    logic [2:0]  exp_done;
    cyc = 0; last_done = 0; n_issue = 0; n_done = 0; prev_req = 1'b0;
    pulse_reset();
    set_add(0, 24'h000010); set_add(1, 24'h000025); set_add(2, 24'h00003F);
    ch_rw = 3'b000; ch_req = 3'b111;
    l2_ready = 1'b1; l2_valid = 1'b1; l2_data = 32'h1234_5678;
    while (n_done < 6 && cyc < 300) begin
      tick();
      cyc++;
      if (l2_req_o && !prev_req) begin
        exp_add = 24'((n_issue % 3 + 1) * 16);
        vec_cnt++; if (l2_add_o !== exp_add) begin err_cnt++; $display("FAIL rr_issue_add[%0d] got %h want %h", n_issue, l2_add_o, exp_add); end
        if (n_done > 0) begin
          vec_cnt++; if (cyc != last_done + 2) begin err_cnt++; $display("FAIL rr_issue_gap[%0d] got %0d want 2", n_issue, cyc - last_done); end
        end
        n_issue++;
      end
      prev_req = l2_req_o;
      if (ch_done_o != 3'b000) begin
        exp_done = 3'(1 << (n_done % 3));
        vec_cnt++; if (ch_done_o !== exp_done) begin err_cnt++; $display("FAIL rr_done_order[%0d] got %b want %b", n_done, ch_done_o, exp_done); end
        last_done = cyc;
        n_done++;
        if (n_done == 6) ch_req = 3'b000;
      end
    end
    vec_cnt++; if (n_done != 6) begin err_cnt++; $display("FAIL rr_timeout got %0d dones want 6", n_done); end
    l2_valid = 1'b0; l2_ready = 1'b0;
    tick();
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("FAIL rr_idle got %0b want 0", busy_o); end
    vec_cnt++; if (grant_cnt_o !== {32'd2, 32'd2, 32'd2}) begin err_cnt++; $display("FAIL rr_counts got %h want 2 each", grant_cnt_o); end
  endtask

  task automatic test_write_ch2();
    int acc, k;
    set_add(2, 24'h000047);
    ch_wdata[31:0] = 32'h1111_1111; ch_wdata[63:32] = 32'h2222_2222; ch_wdata[95:64] = 32'hC0DE_0000;
    ch_rw = 3'b100; ch_req = 3'b100; l2_ready = 1'b0; l2_wready = 1'b0; l2_valid = 1'b0;
    tick();
    vec_cnt++; if ({l2_req_o, l2_rw_o, l2_wvalid_o} !== 3'b110) begin err_cnt++; $display("FAIL wr_issue req/rw/wvalid got %b want 110", {l2_req_o, l2_rw_o, l2_wvalid_o}); end
    vec_cnt++; if (l2_add_o !== 24'h000040) begin err_cnt++; $display("FAIL wr_issue_add got %h want 000040", l2_add_o); end
    l2_ready = 1'b1;
    tick();
    l2_ready = 1'b0;
    vec_cnt++; if ({l2_req_o, l2_wvalid_o} !== 2'b01) begin err_cnt++; $display("FAIL wr_enter req/wvalid got %b want 01", {l2_req_o, l2_wvalid_o}); end
    acc = 0; k = 0;
    while (acc < 16 && k < 64) begin
      l2_wready = (k % 2 == 0);
      ch_wdata[95:64] = 32'hC0DE_0000 + 32'(acc);
      #1;
      vec_cnt++; if (ch_wnext_o !== (l2_wready ? 3'b100 : 3'b000)) begin err_cnt++; $display("FAIL wr_wnext[%0d] got %b want %b", k, ch_wnext_o, l2_wready ? 3'b100 : 3'b000); end
      vec_cnt++; if (l2_wdata_o !== 32'hC0DE_0000 + 32'(acc)) begin err_cnt++; $display("FAIL wr_wdata[%0d] got %h want %h", k, l2_wdata_o, 32'hC0DE_0000 + 32'(acc)); end
      vec_cnt++; if ({l2_wvalid_o, ch_done_o} !== 4'b1000) begin err_cnt++; $display("FAIL wr_wvalid_done[%0d] got %b want 1000", k, {l2_wvalid_o, ch_done_o}); end
      if (l2_wready) acc++;
      k++;
      tick();
    end
    vec_cnt++; if (k != 31) begin err_cnt++; $display("FAIL wr_cycles got %0d want 31", k); end
    l2_wready = 1'b1;
    #1;
    vec_cnt++; if (ch_done_o !== 3'b100) begin err_cnt++; $display("FAIL wr_done got %b want 100", ch_done_o); end
    vec_cnt++; if ({l2_wvalid_o, ch_wnext_o, l2_wdata_o} !== 36'h0) begin err_cnt++; $display("FAIL wr_done_quiet got %h want 0", {l2_wvalid_o, ch_wnext_o, l2_wdata_o}); end
    ch_req = 3'b000; l2_wready = 1'b0;
    tick();
    vec_cnt++; if ({busy_o, ch_done_o} !== 4'h0) begin err_cnt++; $display("FAIL wr_after_done got %b want 0", {busy_o, ch_done_o}); end
  endtask

  task automatic test_fixed_priority();
    int cyc, n_issue, n_done;
    logic prev_req;
    logic [23:0] exp_add;
    logic [2:0]  exp_done;
    cyc = 0; n_issue = 0; n_done = 0; prev_req = 1'b0;
    pulse_reset();
    set_add(0, 24'h000500); set_add(2, 24'h000600);
    ch_rw = 3'b000; ch_req = 3'b101;
    l2_ready = 1'b1; l2_valid = 1'b1; l2_data = 32'h0BAD_F00D;
    while (n_done < 4 && cyc < 200) begin
      tick();
      cyc++;
      if (p_l2_req_o && !prev_req) begin
        exp_add = (n_issue < 3) ? 24'h000500 : 24'h000600;
        vec_cnt++; if (p_l2_add_o !== exp_add) begin err_cnt++; $display("FAIL fp_issue_add[%0d] got %h want %h", n_issue, p_l2_add_o, exp_add); end
        n_issue++;
      end
      prev_req = p_l2_req_o;
      if (p_ch_done_o != 3'b000) begin
        exp_done = (n_done < 3) ? 3'b001 : 3'b100;
        vec_cnt++; if (p_ch_done_o !== exp_done) begin err_cnt++; $display("FAIL fp_done[%0d] got %b want %b", n_done, p_ch_done_o, exp_done); end
        n_done++;
        if (n_done == 3) ch_req = 3'b100;
        if (n_done == 4) ch_req = 3'b000;
      end
    end
    vec_cnt++; if (n_done != 4) begin err_cnt++; $display("FAIL fp_timeout got %0d dones want 4", n_done); end
    vec_cnt++; if (p_grant_cnt_o !== {32'd1, 32'd0, 32'd3}) begin err_cnt++; $display("FAIL fp_counts got %h want ch0=3 ch2=1", p_grant_cnt_o); end
    l2_valid = 1'b0; l2_ready = 1'b0;
    pulse_reset();
  endtask

  task automatic test_grant_saturation();
    force dut.grant_cnt_q = '1;
    tick();
    release dut.grant_cnt_q;
    vec_cnt++; if (grant_cnt_o[63:32] !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sat_preload got %h want FFFFFFFF", grant_cnt_o[63:32]); end
    set_add(1, 24'h000707);
    ch_rw = 3'b000; ch_req = 3'b010;
    tick();
    vec_cnt++; if (l2_add_o !== 24'h000700) begin err_cnt++; $display("FAIL sat_grant_add got %h want 000700", l2_add_o); end
    vec_cnt++; if (grant_cnt_o[63:32] !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sat_hold got %h want FFFFFFFF", grant_cnt_o[63:32]); end
    vec_cnt++; if (grant_cnt_o[31:0] !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL sat_other got %h want FFFFFFFF", grant_cnt_o[31:0]); end
    ch_req = 3'b000;
    pulse_reset();
  endtask

  initial begin
    rst = 1'b1; ch_req = '0; ch_rw = '0; ch_add = '0; ch_wdata = '0;
    l2_ready = 1'b0; l2_data = '0; l2_valid = 1'b0; l2_wready = 1'b0;
    test_reset();
    test_read_ch1();
    test_reset_mid_read();
    test_round_robin();
    test_write_ch2();
    test_fixed_priority();
    test_grant_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1);
  end

endmodule
